// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: constants and state encoding shared by the fetch unit.
package instruction_fetch_unit_pkg;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;
endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and IF/ID loader over a 1-cycle synchronous instruction memory,
// with a one-entry skid buffer for decode stalls and squash-on-redirect.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = instruction_fetch_unit_pkg::RESET_PC,
    parameter logic [31:0] NOP_WORD = instruction_fetch_unit_pkg::NOP_WORD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instruction,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] pc
);
    import instruction_fetch_unit_pkg::*;

    state_e      state_q;
    logic [31:0] pc_q, inflight_pc_q, skid_instr_q, skid_pc_q;
    logic [31:0] if_id_instr_q, if_id_pc_plus4_q;
    logic        inflight_valid_q, skid_valid_q, if_id_valid_q;
    logic [31:0] ld_instr_d, ld_pc_d;
    logic        ld_valid_d;

    // In HOLD the skid carries the word that was returned when the stall began.
    always_comb begin
        ld_instr_d = state_q == HOLD ? skid_instr_q : instruction;
        ld_pc_d    = state_q == HOLD ? skid_pc_q : inflight_pc_q;
        ld_valid_d = state_q == HOLD ? skid_valid_q : inflight_valid_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q             <= RESET_PC;
            inflight_pc_q    <= '0;
            inflight_valid_q <= 1'b0;
            skid_instr_q     <= NOP_WORD;
            skid_pc_q        <= '0;
            skid_valid_q     <= 1'b0;
            state_q          <= RUN;
            if_id_instr_q    <= NOP_WORD;
            if_id_pc_plus4_q <= '0;
            if_id_valid_q    <= 1'b0;
        end else if (branch_taken) begin
            pc_q             <= {branch_target[31:2], 2'b00};
            inflight_valid_q <= 1'b0;
            skid_valid_q     <= 1'b0;
            state_q          <= RUN;
            if_id_instr_q    <= NOP_WORD;
            if_id_valid_q    <= 1'b0;
        end else if (stall) begin
            if (state_q == RUN) begin
                skid_instr_q <= instruction;
                skid_pc_q    <= inflight_pc_q;
                skid_valid_q <= inflight_valid_q;
                state_q      <= HOLD;
            end
        end else begin
            if_id_instr_q    <= ld_instr_d;
            if_id_pc_plus4_q <= ld_pc_d + 32'd4;
            if_id_valid_q    <= ld_valid_d;
            inflight_pc_q    <= pc_q;
            inflight_valid_q <= 1'b1;
            pc_q             <= pc_q + 32'd4;
            skid_valid_q     <= 1'b0;
            state_q          <= RUN;
        end
    end

    assign instructionAddress = pc_q;
    assign pc                 = pc_q;
    assign if_id_instruction  = if_id_instr_q;
    assign if_id_pc_plus4     = if_id_pc_plus4_q;
    assign if_id_valid        = if_id_valid_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench; the expected IF/ID stream is the program-order word
// sequence from the last reset/redirect, preceded by exactly one bubble load.
module tb_instruction_fetch_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] instructionAddress, instruction, if_id_instruction, if_id_pc_plus4, pc;
    logic        if_id_valid;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] p4;
    } exp_t;

    exp_t        q[$];
    logic [31:0] nxt = '0;
    int          total = 0;
    int          bad = 0;

    instruction_fetch_unit dut (
        .CLK(CLK), .RST(RST), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .instructionAddress(instructionAddress),
        .instruction(instruction), .if_id_instruction(if_id_instruction),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .pc(pc)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    always @(posedge CLK) instruction <= word_at(instructionAddress);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic restart(input logic [31:0] base);
        q.delete();
        q.push_back('{1'b0, 32'h0, 32'h0});
        nxt = base;
    endtask

    task automatic cyc(input logic r, input logic b, input logic [31:0] t, input logic s);
        @(negedge CLK);
        RST = r;
        branch_taken = b;
        branch_target = t;
        stall = s;
        if (r) restart(32'h0);
        else if (b) restart(t & ~32'h3);
        while (q.size() < 8) begin
            q.push_back('{1'b1, word_at(nxt), nxt + 32'd4});
            nxt += 32'd4;
        end
    endtask

    task automatic after_edge;
        @(posedge CLK);
        #2;
    endtask

    logic        e_rst, e_br, e_st, armed = 1'b0;
    logic [31:0] e_tgt, prev_pc, prev_ins, prev_p4;
    logic        prev_v;
    exp_t        e;

    always @(posedge CLK) begin
        e_rst = RST;
        e_br  = branch_taken;
        e_st  = stall;
        e_tgt = branch_target;
        #1;
        if (e_rst) begin
            chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
            chk("rst_instr", if_id_instruction, 32'h0);
            chk("rst_pcp4", if_id_pc_plus4, 32'h0);
            chk("rst_pc", pc, 32'h0);
        end else if (armed) begin
            if (e_br) begin
                chk("br_valid", {31'b0, if_id_valid}, 32'd0);
                chk("br_instr", if_id_instruction, 32'h0);
                chk("br_pc", pc, e_tgt & ~32'h3);
            end else if (e_st) begin
                chk("stall_pc", pc, prev_pc);
                chk("stall_valid", {31'b0, if_id_valid}, {31'b0, prev_v});
                chk("stall_instr", if_id_instruction, prev_ins);
                chk("stall_pcp4", if_id_pc_plus4, prev_p4);
            end else begin
                chk("run_pc", pc, prev_pc + 32'd4);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty got=load want=none at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("sb_valid", {31'b0, if_id_valid}, {31'b0, e.v});
                    if (e.v) begin
                        chk("sb_instr", if_id_instruction, e.ins);
                        chk("sb_pcp4", if_id_pc_plus4, e.p4);
                    end
                end
            end
        end
        chk("addr_eq_pc", instructionAddress, pc);
        prev_pc  = pc;
        prev_v   = if_id_valid;
        prev_ins = if_id_instruction;
        prev_p4  = if_id_pc_plus4;
        armed    = armed | e_rst;
    end

    initial begin
        restart(32'h0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        repeat (3) begin
            cyc(0, 0, 0, 1);
            after_edge;
            chk("stall_addr16", instructionAddress, 32'd16);
            chk("stall_holdA2", if_id_instruction, 32'hA000_0002);
        end
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h40, 0);
        after_edge;
        chk("br_bubble1", {31'b0, if_id_valid}, 32'd0);
        cyc(0, 0, 0, 0);
        after_edge;
        chk("br_bubble2", {31'b0, if_id_valid}, 32'd0);
        cyc(0, 0, 0, 0);
        after_edge;
        chk("br_tgt_instr", if_id_instruction, 32'hA000_0010);
        chk("br_tgt_pcp4", if_id_pc_plus4, 32'h44);
        repeat (3) cyc(0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h40, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        after_edge;
        chk("brst_instr", if_id_instruction, 32'hA000_0010);
        chk("brst_pcp4", if_id_pc_plus4, 32'h44);
        cyc(0, 1, 32'h43, 0);
        after_edge;
        chk("misalign_addr", instructionAddress, 32'h40);
        repeat (2) cyc(0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        after_edge;
        chk("holdrst_pc", pc, 32'h0);
        chk("holdrst_valid", {31'b0, if_id_valid}, 32'd0);
        repeat (3) cyc(0, 0, 0, 0);
        after_edge;
        chk("holdrst_A1", if_id_instruction, 32'hA000_0001);
        cyc(0, 1, 32'hFFFF_FFF8, 0);
        repeat (2) cyc(0, 0, 0, 0);
        after_edge;
        chk("wrap_addr", instructionAddress, 32'h0);
        repeat (4) cyc(0, 0, 0, 0);
        repeat (3000)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, $urandom,
                $urandom_range(0, 3) == 0);
        repeat (3) cyc(0, 0, 0, 0);
        after_edge;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
